// File: rtl/lsu_sram_master_pkg.sv
// Shared encodings for the LSU SRAM initiator: access sizes, FSM states,
// and the alignment rule applied to every incoming request.
package lsu_sram_master_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CMD  = 2'b01,
    ST_RSP  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // True when a request can never reach the SRAM: misaligned half/word or
  // the reserved size code.
  function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      SZ_W:    return |addr_lo;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering between the pipeline and the SRAM word bus:
// store side builds the write mask and replicated data, load side picks the
// addressed lane and sign/zero-extends it.
module lsu_align
  import lsu_sram_master_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]          i_size,
  input  logic [1:0]          i_addr_lo,
  input  logic                i_signed,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W-1:0]   i_rdata,
  output logic [DATA_W/8-1:0] o_wmask,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W-1:0]   o_rdata
);

  localparam int MASK_W = DATA_W / 8;

  logic [DATA_W-1:0] w_shift_b;
  logic [DATA_W-1:0] w_shift_h;

  assign w_shift_b = i_rdata >> {i_addr_lo, 3'b000};
  assign w_shift_h = i_rdata >> {i_addr_lo[1], 4'b0000};

  // Store lane mask and replicated write data
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    o_wmask = '1;
    o_wdata = i_wdata;
    case (i_size)
      SZ_B: begin
        o_wmask = MASK_W'(1) << i_addr_lo;
        o_wdata = {(DATA_W/8){i_wdata[7:0]}};
      end
      SZ_H: begin
        o_wmask = MASK_W'(3) << {i_addr_lo[1], 1'b0};
        o_wdata = {(DATA_W/16){i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extract and extension
  always_comb begin
    o_rdata = i_rdata;
    case (i_size)
      SZ_B: o_rdata = {{(DATA_W-8){i_signed & w_shift_b[7]}}, w_shift_b[7:0]};
      SZ_H: o_rdata = {{(DATA_W-16){i_signed & w_shift_h[15]}}, w_shift_h[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_sram_master.sv
// Single-outstanding load/store initiator on the sram_cmd/sram_rsp
// valid-ready bus. Requests are latched in IDLE, issued in CMD, answered in
// RSP and handed back to the pipeline from DONE.
module lsu_sram_master
  import lsu_sram_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_vld,
  output logic                o_req_rdy,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic                i_req_read,
  input  logic [1:0]          i_req_size,
  input  logic                i_req_signed,
  input  logic [DATA_W-1:0]   i_req_wdata,
  output logic                o_done_vld,
  input  logic                i_done_rdy,
  output logic [DATA_W-1:0]   o_done_rdata,
  output logic                o_done_err,
  output logic                o_sram_cmd_vld,
  input  logic                i_sram_cmd_rdy,
  output logic [ADDR_W-1:0]   o_sram_cmd_addr,
  output logic                o_sram_cmd_read,
  output logic [DATA_W-1:0]   o_sram_cmd_wdata,
  output logic [DATA_W/8-1:0] o_sram_cmd_wmask,
  input  logic                i_sram_rsp_vld,
  output logic                o_sram_rsp_rdy,
  input  logic                i_sram_rsp_err,
  input  logic [DATA_W-1:0]   i_sram_rsp_rdata
);

  state_e              r_state;
  state_e              w_next;

  logic [ADDR_W-1:0]   r_addr;
  logic                r_read;
  logic [1:0]          r_size;
  logic                r_signed;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_done_rdata;
  logic                r_done_err;

  logic                w_accept;
  logic                w_bad;
  logic                w_rsp_fire;
  logic [DATA_W/8-1:0] w_wmask;
  logic [DATA_W-1:0]   w_lane_wdata;
  logic [DATA_W-1:0]   w_load_data;

  assign w_accept   = (r_state == ST_IDLE) && i_req_vld;
  assign w_bad      = is_bad_req(i_req_size, i_req_addr[1:0]);
  assign w_rsp_fire = (r_state == ST_RSP) && i_sram_rsp_vld;

  lsu_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .i_size    (r_size),
    .i_addr_lo (r_addr[1:0]),
    .i_signed  (r_signed),
    .i_wdata   (r_wdata),
    .i_rdata   (i_sram_rsp_rdata),
    .o_wmask   (w_wmask),
    .o_wdata   (w_lane_wdata),
    .o_rdata   (w_load_data)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (!i_rst) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_req_vld)      w_next = w_bad ? ST_DONE : ST_CMD;
      ST_CMD:  if (i_sram_cmd_rdy) w_next = ST_RSP;
      ST_RSP:  if (i_sram_rsp_vld) w_next = ST_DONE;
      ST_DONE: if (i_done_rdy)     w_next = ST_IDLE;
      default:                     w_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    o_req_rdy      = 1'b0;
    o_sram_cmd_vld = 1'b0;
    o_sram_rsp_rdy = 1'b0;
    o_done_vld     = 1'b0;
    case (r_state)
      ST_IDLE: o_req_rdy      = 1'b1;
      ST_CMD:  o_sram_cmd_vld = 1'b1;
      ST_RSP:  o_sram_rsp_rdy = 1'b1;
      ST_DONE: o_done_vld     = 1'b1;
      default: ;
    endcase
  end

  // Request latch on acceptance, completion capture on response
  always_ff @(posedge i_clk or negedge i_rst) begin
    // NOTE: the request payload is reset as well so command fields are never
    // X, even though they are only observed after a capture.
    if (!i_rst) begin
      r_addr       <= '0;
      r_read       <= 1'b0;
      r_size       <= SZ_B;
      r_signed     <= 1'b0;
      r_wdata      <= '0;
      r_done_rdata <= '0;
      r_done_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr       <= i_req_addr;
        r_read       <= i_req_read;
        r_size       <= i_req_size;
        r_signed     <= i_req_signed;
        r_wdata      <= i_req_wdata;
        r_done_rdata <= '0;
        r_done_err   <= w_bad;
      end
      if (w_rsp_fire) begin
        r_done_err   <= i_sram_rsp_err;
        r_done_rdata <= (i_sram_rsp_err || !r_read) ? '0 : w_load_data;
      end
    end
  end

  assign o_sram_cmd_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign o_sram_cmd_read  = r_read;
  assign o_sram_cmd_wdata = w_lane_wdata;
  assign o_sram_cmd_wmask = r_read ? '0 : w_wmask;
  assign o_done_rdata     = r_done_rdata;
  assign o_done_err       = r_done_err;

endmodule
